// File: rtl/rank_sweep_sequencer_if.sv
// Handshake bundle for rank_sweep_sequencer: load channel, tag channel and status.
// The master modport is the producer/consumer side; the slave modport is the sequencer.
interface rank_sweep_sequencer_if #(
  parameter int unsigned SIZE = 16,
  parameter int unsigned K    = 8
);
  localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_key;
  logic          out_valid;
  logic          out_ready;
  logic [KW-1:0] out_tag;
  logic [AW-1:0] out_key;
  logic          busy;
  logic          done;

  modport master (
    output start, in_valid, in_key, out_ready,
    input  in_ready, out_valid, out_tag, out_key, busy, done
  );

  modport slave (
    input  start, in_valid, in_key, out_ready,
    output in_ready, out_valid, out_tag, out_key, busy, done
  );
endinterface

// File: rtl/rank_sweep_sequencer.sv
// Loads K keys, then sweeps a key pointer and emits matching load indices as a ranked stream.
// Define RANK_SWEEP_DESC_EN for a descending sweep (SIZE-1 down to 0); ties stay lowest index first.
module rank_sweep_sequencer #(
  parameter int unsigned SIZE = 16,
  parameter int unsigned K    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  rank_sweep_sequencer_if.slave   sif
);
  localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StSweep = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

`ifdef RANK_SWEEP_DESC_EN
  localparam logic [AW-1:0] NFirst = AW'(SIZE - 1);
  localparam logic [AW-1:0] NLast  = '0;
`else
  localparam logic [AW-1:0] NFirst = '0;
  localparam logic [AW-1:0] NLast  = AW'(SIZE - 1);
`endif

  logic [1:0]    r_state;
  logic [KW-1:0] r_cnt;
  logic [AW-1:0] r_n;
  logic [AW-1:0] r_key [K];
  logic [K-1:0]  r_pending;

  logic [K-1:0]  w_hit;
  logic [K-1:0]  w_tag_oh;
  logic [KW-1:0] w_tag;
  logic          w_any_hit;
  logic          w_in_sweep;
  logic          w_fire;
  logic          w_advance;
  logic [AW-1:0] w_n_next;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < int'(K); i++) begin
      w_hit[i] = r_pending[i] && (r_key[i] == r_n);
    end
  end

  // Scan from the top so the lowest set index is the one that sticks.
  always_comb begin
    w_tag    = '0;
    w_tag_oh = '0;
    for (int i = int'(K) - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_tag       = KW'(i);
        w_tag_oh    = '0;
        w_tag_oh[i] = 1'b1;
      end
    end
  end

  assign w_any_hit  = |w_hit;
  assign w_in_sweep = (r_state == StSweep);
  assign w_fire     = w_in_sweep && w_any_hit && sif.out_ready;
  // Move on when nothing matches, or when the tag just taken was the last match for this key.
  assign w_advance  = w_in_sweep &&
                      (!w_any_hit || (sif.out_ready && ((w_hit & ~w_tag_oh) == '0)));

`ifdef RANK_SWEEP_DESC_EN
  assign w_n_next = r_n - AW'(1);
`else
  assign w_n_next = r_n + AW'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_n       <= '0;
      r_pending <= '0;
      for (int i = 0; i < int'(K); i++) begin
        r_key[i] <= '0;
      end
    end else begin
      case (r_state)
        StIdle: begin
          if (sif.start) begin
            r_state   <= StLoad;
            r_cnt     <= '0;
            r_pending <= '0;
          end
        end
        StLoad: begin
          if (sif.in_valid) begin
            r_key[r_cnt]     <= sif.in_key;
            r_pending[r_cnt] <= 1'b1;
            if (r_cnt == KW'(K - 1)) begin
              r_state <= StSweep;
              r_cnt   <= '0;
              r_n     <= NFirst;
            end else begin
              r_cnt <= r_cnt + KW'(1);
            end
          end
        end
        StSweep: begin
          if (w_fire) begin
            r_pending[w_tag] <= 1'b0;
          end
          if (w_advance) begin
            if (r_n == NLast) begin
              r_state <= StDone;
            end else begin
              r_n <= w_n_next;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign sif.in_ready  = (r_state == StLoad) && !rst;
  assign sif.out_valid = w_in_sweep && w_any_hit && !rst;
  assign sif.out_tag   = (w_in_sweep && w_any_hit && !rst) ? w_tag : '0;
  assign sif.out_key   = (w_in_sweep && !rst) ? r_n : '0;
  assign sif.busy      = (r_state != StIdle) && !rst;
  assign sif.done      = (r_state == StDone) && !rst;

endmodule

// File: tb/tb_rank_sweep_sequencer.sv
// Directed self-checking bench for rank_sweep_sequencer (SIZE=16, K=8).
// Expectations follow RANK_SWEEP_DESC_EN when the macro is defined.
module tb_rank_sweep_sequencer;
  typedef int unsigned arr_t [8];

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rank_sweep_sequencer_if #(.SIZE(16), .K(8)) sif ();

  rank_sweep_sequencer #(.SIZE(16), .K(8)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a load from IDLE and feeds 8 beats; returns on the negedge of the first SWEEP cycle.
  task automatic do_load(input arr_t keys);
    @(negedge clk);
    chk("idle_in_ready", {31'd0, sif.in_ready}, 0);
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sif.in_valid = 1'b1;
      sif.in_key   = keys[i][3:0];
      chk("load_in_ready", {31'd0, sif.in_ready}, 1);
      @(negedge clk);
    end
    sif.in_valid = 1'b0;
  endtask

  // Walks the sweep at negedges, checking tag/key order, stalls and cycle count.
  task automatic run_sweep(input arr_t ex_tag, input arr_t ex_key, input int exp_cycles,
                           input int stall_idx, input int stall_n, input int start_cyc,
                           input int max_tags);
    int cyc;
    int idx;
    int stalled;
    cyc     = 0;
    idx     = 0;
    stalled = 0;
    while (sif.busy && !sif.done && cyc < 200) begin
      cyc++;
      sif.start = (cyc == start_cyc);
      if (sif.out_valid) begin
        if (idx < 8) begin
          chk("out_tag", {29'd0, sif.out_tag}, ex_tag[idx]);
          chk("out_key", {28'd0, sif.out_key}, ex_key[idx]);
        end else begin
          chk("extra_tag", idx, 7);
        end
        if (idx == stall_idx && stalled < stall_n) begin
          sif.out_ready = 1'b0;
          stalled++;
        end else begin
          sif.out_ready = 1'b1;
          idx++;
        end
      end else begin
        sif.out_ready = 1'b1;
      end
      if (idx == max_tags && max_tags < 8) break;
      @(negedge clk);
    end
    sif.start     = 1'b0;
    sif.out_ready = 1'b1;
    if (max_tags == 8) begin
      chk("tag_count", idx, 8);
      chk("sweep_cycles", cyc, exp_cycles);
      chk("done_pulse", {31'd0, sif.done}, 1);
      chk("done_busy", {31'd0, sif.busy}, 1);
      chk("done_out_valid", {31'd0, sif.out_valid}, 0);
      @(negedge clk);
      chk("done_cleared", {31'd0, sif.done}, 0);
      chk("busy_after", {31'd0, sif.busy}, 0);
    end
  endtask

  arr_t k1;
  arr_t k5;
  arr_t t1;
  arr_t e1;
  arr_t t5;
  arr_t e5;
  int   stall_pos;

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    sif.start     = 1'b0;
    sif.in_valid  = 1'b0;
    sif.in_key    = '0;
    sif.out_ready = 1'b1;

    k1 = '{7, 3, 0, 15, 9, 1, 4, 12};
    k5 = '{5, 5, 5, 5, 5, 5, 5, 5};
    t5 = '{0, 1, 2, 3, 4, 5, 6, 7};
    e5 = '{5, 5, 5, 5, 5, 5, 5, 5};
`ifdef RANK_SWEEP_DESC_EN
    t1 = '{3, 7, 4, 0, 6, 1, 5, 2};
    e1 = '{15, 12, 9, 7, 4, 3, 1, 0};
    stall_pos = 7;
`else
    t1 = '{2, 5, 1, 6, 0, 4, 7, 3};
    e1 = '{0, 1, 3, 4, 7, 9, 12, 15};
    stall_pos = 0;
`endif

    // Reset state
    #3;
    chk("rst_in_ready", {31'd0, sif.in_ready}, 0);
    chk("rst_out_valid", {31'd0, sif.out_valid}, 0);
    chk("rst_busy", {31'd0, sif.busy}, 0);
    chk("rst_done", {31'd0, sif.done}, 0);
    chk("rst_out_tag", {29'd0, sif.out_tag}, 0);
    chk("rst_out_key", {28'd0, sif.out_key}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Distinct keys
    do_load(k1);
    chk("first_valid", {31'd0, sif.out_valid}, 1);
    run_sweep(t1, e1, 16, -1, 0, 0, 8);

    // All keys equal
    do_load(k5);
    run_sweep(t5, e5, 23, -1, 0, 0, 8);

    // Backpressure on the tag-2 beat
    do_load(k1);
    run_sweep(t1, e1, 19, stall_pos, 3, 0, 8);

    // Reset after the third emitted tag
    do_load(k1);
    run_sweep(t1, e1, 0, -1, 0, 0, 3);
    @(posedge clk);
    chk("mid_busy", {31'd0, sif.busy}, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, sif.out_valid}, 0);
    chk("abort_busy", {31'd0, sif.busy}, 0);
    chk("abort_in_ready", {31'd0, sif.in_ready}, 0);
    chk("abort_done", {31'd0, sif.done}, 0);
    @(negedge clk);
    rst = 1'b0;
    do_load(k1);
    run_sweep(t1, e1, 16, -1, 0, 0, 8);

    // Handshake guards: in_valid while IDLE, start pulse mid-sweep
    sif.in_valid = 1'b1;
    sif.in_key   = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_guard_ready", {31'd0, sif.in_ready}, 0);
      chk("idle_guard_busy", {31'd0, sif.busy}, 0);
    end
    sif.in_valid = 1'b0;
    do_load(k1);
    run_sweep(t1, e1, 16, -1, 0, 4, 8);
    @(negedge clk);
    chk("start_ignored", {31'd0, sif.busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rank_sweep_sequencer.md
Name: rank_sweep_sequencer

Overview:
- Loads K keyed entries serially, then sweeps a key pointer N across 0..SIZE-1.
- For every pending entry whose key equals N, it emits that entry's load index (tag).
- This is the sequencer for the address-match selection datapath, with one change: the datapath ORs coincident matches together, whereas this block serializes duplicate keys one per handshake, lowest index first.
- Result: a stable ranked (counting-sort) stream of tags.

Parameters:
- SIZE, 16, key range; AW = $clog2(SIZE) key bits.
- K, 8, number of entries; KW = $clog2(K) tag bits.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a load; honoured only in IDLE
- in_valid  input  1  load beat valid
- in_ready  output  1  block can accept a load beat
- in_key  input  AW  key of the current load beat
- out_valid  output  1  tag available
- out_ready  input  1  consumer accepts tag
- out_tag  output  KW  load index of the emitted entry
- out_key  output  AW  key (current N) of the emitted entry
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at sweep completion

Behaviour:
- Storage and reset:
  - Storage: key[0..K-1] (AW bits each) plus a K-bit pending mask.
  - rst asserted asynchronously forces IDLE; clears pending, load counter and N.
  - During reset all outputs are 0, including in_ready.
- States: IDLE, LOAD, SWEEP, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> LOAD next edge; load count cnt=0.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: key[cnt] <= in_key, pending[cnt] <= 1, cnt++.
  - After the K-th accepted beat: state -> SWEEP and N <= 0 on the same edge.
  - No timeout; a stalled producer leaves the block in LOAD.
- SWEEP:
  - hit[i] = pending[i] & (key[i]==N), combinational.
  - out_valid = |hit; out_tag = lowest i with hit[i]; out_key = N. All are combinational from registered state.
  - out_valid & out_ready: clear pending[out_tag]. If no other hit bit remains, N advances on the same edge.
  - out_valid=0: N advances next edge.
  - Advance from N=SIZE-1 (the last key) goes to DONE instead.
  - While out_valid=1 and out_ready=0: out_tag/out_key are held stable; N does not move; no tag is dropped.
  - Cycle count (out_ready held 1): SWEEP lasts SIZE + (K - number of distinct keys) cycles.
  - First tag is presentable the cycle after the K-th load beat.
- DONE:
  - done=1 for exactly one cycle, busy=1, out_valid=0.
  - Then -> IDLE.
- Exactly K tags are emitted per run.
- Keys wrap-free: N is AW bits; the sweep terminates at the last key, never wraps.
- If SIZE is not a power of two, keys >= SIZE are accepted but never emitted; done still pulses.
- rst mid-LOAD or mid-SWEEP aborts the run; the next start begins a fresh load.

Optional Feature:
- Macro: RANK_SWEEP_DESC_EN.
- Defined:
  - Sweep starts at N=SIZE-1 and decrements.
  - Terminates after N=0.
  - Ties remain lowest index first.
- Undefined: ascending sweep as above.
- Port list identical in both builds.

Test Plan:
- Ascending sweep, distinct keys (K=8, SIZE=16):
  - Stimulus: load keys 7,3,0,15,9,1,4,12; out_ready=1.
  - Required: tags 2,5,1,6,0,4,7,3 with out_key 0,1,3,4,7,9,12,15; SWEEP 16 cycles; done one pulse; busy low after.
- All keys equal:
  - Stimulus: load all keys=5; out_ready=1.
  - Required: tags 0..7 on 8 consecutive cycles, out_key=5 each; SWEEP 23 cycles.
- Backpressure:
  - Stimulus: keys as in the first test; out_ready=0 for 3 cycles while the tag-2 beat is valid.
  - Required: out_tag=2, out_key=0 held stable for 3 cycles; sequence otherwise unchanged; no missing or duplicate tag.
- Reset mid-sweep:
  - Stimulus: assert rst after the 3rd emitted tag.
  - Required: out_valid, busy, in_ready, done immediately 0. A following start plus 8 beats reloads; the full first-test sequence repeats.
- Handshake guards:
  - Stimulus: in_valid=1 while IDLE; start pulse during SWEEP.
  - Required: in IDLE, no beat accepted (in_ready=0). In SWEEP, start has no effect on N, pending or the tag order.
- RANK_SWEEP_DESC_EN build:
  - Stimulus: first-test keys.
  - Required: out_key 15,12,9,7,4,3,1,0 with tags 3,7,4,0,6,1,5,2.
